posicionador_frota: RTL
=======================

Name: posicionador_frota

Overview:
Parametrised successor to the piece-placement FSM. It walks both players through placing a configurable fleet on a configurable board. It debounces the active-low enter/select buttons into edge events and runs an explicit conflict-check handshake with the board checker, retrying the piece on conflict. It emits a one-cycle write strobe per accepted piece and asserts ready when the fleet is complete.

Parameters:
COORD_W, 3, width of X1/Y1
BOARD_MAX, 7, highest coordinate value; select wraps BOARD_MAX -> 0
QT_SUB, 5, submarine count (tipo 1)
QT_CRUZ, 2, cruiser count (tipo 2)
QT_HIDRO, 2, seaplane count (tipo 3)
QT_ENC, 1, battleship count (tipo 4)
QT_PA, 1, aircraft-carrier count (tipo 5)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
enable  in  1  0 freezes FSM and all outputs
enter  in  1  active-low button level
select  in  1  active-low button level
mode  in  1  0 = player vs player (both place); 1 = vs CPU (player 0 only)
conflito  in  1  checker result, sampled only when check_done=1
check_done  in  1  checker response strobe
ready  out  1  fleet fully placed
valida  out  1  one-cycle check request
gravar  out  1  one-cycle store strobe
erro  out  1  one-cycle conflict indication
tipo  out  3  current ship type 1..5; 0 when idle or done
jogador  out  1  current player
X1  out  COORD_W  current column
Y1  out  COORD_W  current row
direcao  out  1  0 horizontal, 1 vertical
orientacao  out  1  placement sense
restantes  out  4  pieces left of current type, including current

Behaviour:
- Reset (sync, high): state IDLE. ready, valida, gravar, erro = 0. tipo = 0, jogador = 0. X1, Y1, direcao, orientacao = 0. restantes = 0. Edge-detector history = 1.
- Edge events: ent_ev / sel_ev = 1-cycle pulse on a registered 1->0 transition of enter/select. History keeps updating while enable = 0, but events are discarded. If both events fire in the same cycle, enter wins and select is dropped.
- States: IDLE, DIRECAO, ORIENTACAO, DEF_X, DEF_Y, VERIFICA, ESPERA, ARMAZENA, PRONTO.
- IDLE: ent_ev -> DIRECAO. Load the first type with nonzero count into tipo and that count into restantes.
- DIRECAO: sel_ev toggles direcao; ent_ev -> ORIENTACAO.
- ORIENTACAO: sel_ev toggles orientacao; ent_ev -> DEF_X.
- DEF_X and DEF_Y: sel_ev increments X1 (resp. Y1), wrapping BOARD_MAX -> 0. ent_ev moves DEF_X -> DEF_Y and DEF_Y -> VERIFICA.
- VERIFICA: valida = 1 for exactly this one cycle, then ESPERA.
- ESPERA: buttons ignored.
  - check_done with conflito = 1: erro pulses one cycle; -> DIRECAO. X1, Y1, direcao, orientacao are kept.
  - check_done with conflito = 0: -> ARMAZENA.
  - check_done in the same cycle as VERIFICA is ignored.
- ARMAZENA: ent_ev -> gravar = 1 for one cycle, restantes decrements. Next state:
  - restantes was > 1: same type, -> DIRECAO.
  - Otherwise advance to the next type with nonzero count (zero-count types are skipped), -> DIRECAO.
  - No type left, jogador = 0 and mode = 0: jogador <= 1, reload the first type, -> DIRECAO.
  - Otherwise -> PRONTO.
- X1/Y1/direcao/orientacao are NOT cleared between pieces.
- PRONTO: ready = 1 and tipo = 0; ready holds until reset. All events are ignored.
- mode is sampled only on the IDLE -> DIRECAO transition. Later changes have no effect.
- Reset mid-operation: immediate return to the reset state. No gravar is issued.
- All outputs are registered, with one cycle of latency from event to output change.

Decomposition:
- Package posicionamento_pkg holds:
  - TIPO_* codes 1..5
  - state enum
  - function next_tipo(current, counts) returning the next nonzero type, or 0
- Sub-module detector_borda is the active-low edge detector with an enable gate. It is instantiated twice, for enter and select.
- Total RTL is roughly 200 lines.

Test Plan:
1. Reset then IDLE: enter pulse -> tipo = 1, restantes = 5, jogador = 0, state DIRECAO. All strobes stay 0 throughout.
2. Coordinate wrap: in DEF_X, 9 select pulses with BOARD_MAX = 7 -> X1 = 1. Enter -> DEF_Y. Y1 is unchanged.
3. Conflict retry:
   - check_done with conflito = 1 -> erro one pulse, no gravar, back to DIRECAO, X1/Y1 retained.
   - Second attempt with conflito = 0, then enter -> gravar one pulse, restantes = 4.
4. Full PvP fleet, mode = 0, default counts: 22 gravar pulses in total, jogador flips 0 -> 1 after the 11th. ready = 1 after the 22nd, tipo = 0.
5. Variants:
   - mode = 1 with QT_CRUZ = 0: type sequence 1,3,4,5 and 9 gravar pulses, then ready with jogador still 0.
   - Simultaneous enter and select edges in DIRECAO -> ORIENTACAO, direcao unchanged.
6. enable = 0 held during 3 select and 1 enter pulses -> no change. Then reset asserted while in ESPERA -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/posicionamento_pkg.sv
// Shared types for the fleet placement block: ship type codes, FSM state
// encoding, per-type count vector and the helpers that walk the fleet list.
// Pure declarations; no latency or flow control of its own.
package posicionamento_pkg;

  localparam logic [2:0] TIPO_NENHUM = 3'd0;
  localparam logic [2:0] TIPO_SUB    = 3'd1;
  localparam logic [2:0] TIPO_CRUZ   = 3'd2;
  localparam logic [2:0] TIPO_HIDRO  = 3'd3;
  localparam logic [2:0] TIPO_ENC    = 3'd4;
  localparam logic [2:0] TIPO_PA     = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DIRECAO,
    ST_ORIENTACAO,
    ST_DEF_X,
    ST_DEF_Y,
    ST_VERIFICA,
    ST_ESPERA,
    ST_ARMAZENA,
    ST_PRONTO
  } estado_t;

  // Piece count per ship type, indexed directly by the type code 1..5.
  typedef logic [5:1][3:0] contagens_t;

  function automatic logic [3:0] contagem(input logic [2:0] tipo, input contagens_t qt);
    case (tipo)
      TIPO_SUB:   return qt[1];
      TIPO_CRUZ:  return qt[2];
      TIPO_HIDRO: return qt[3];
      TIPO_ENC:   return qt[4];
      TIPO_PA:    return qt[5];
      default:    return 4'd0;
    endcase
  endfunction

  // Lowest type code above 'atual' that has pieces to place, or TIPO_NENHUM.
  // Scanning downwards lets the last hit be the smallest qualifying code.
  function automatic logic [2:0] next_tipo(input logic [2:0] atual, input contagens_t qt);
    logic [2:0] r;
    r = TIPO_NENHUM;
    for (int t = 5; t >= 1; t--) begin
      if (t > int'(atual) && qt[t] != 4'd0) r = 3'(t);
    end
    return r;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Falling-edge event detector for an active-low push button, gated by enable.
// Latency: event is asserted in the cycle the pressed level is first seen.
// Backpressure: none; history tracks the button even while events are gated.
// Ports: clk, reset (sync, high), enable (0 drops events), botao (active-low
//        level), evento (single-cycle press pulse).
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic botao,
  output logic evento
);

  logic historico;

  always_ff @(posedge clk) begin
    if (reset) historico <= 1'b1;
    else       historico <= botao;
  end

  assign evento = enable & historico & ~botao;

endmodule

// File: rtl/posicionador_frota.sv
// Piece-placement controller: walks one or two players through placing the
// configured fleet, with a check request/response handshake per piece.
// Latency: every output is registered, one cycle after the triggering event.
// Backpressure: waits indefinitely in ESPERA for check_done; enable=0 freezes.
// Ports: clk, reset (sync, high), enable, enter/select (active-low buttons),
//        mode (0 PvP, 1 vs CPU), conflito/check_done (checker response);
//        ready, valida, gravar, erro (strobes/flags), tipo, jogador, X1, Y1,
//        direcao, orientacao, restantes (current piece description).
module posicionador_frota
  import posicionamento_pkg::*;
#(
  parameter int COORD_W   = 3,
  parameter int BOARD_MAX = 7,
  parameter int QT_SUB    = 5,
  parameter int QT_CRUZ   = 2,
  parameter int QT_HIDRO  = 2,
  parameter int QT_ENC    = 1,
  parameter int QT_PA     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               enter,
  input  logic               select,
  input  logic               mode,
  input  logic               conflito,
  input  logic               check_done,
  output logic               ready,
  output logic               valida,
  output logic               gravar,
  output logic               erro,
  output logic [2:0]         tipo,
  output logic               jogador,
  output logic [COORD_W-1:0] X1,
  output logic [COORD_W-1:0] Y1,
  output logic               direcao,
  output logic               orientacao,
  output logic [3:0]         restantes
);

  localparam contagens_t QT = {4'(QT_PA), 4'(QT_ENC), 4'(QT_HIDRO), 4'(QT_CRUZ), 4'(QT_SUB)};
  localparam logic [2:0] PRIMEIRO = next_tipo(TIPO_NENHUM, QT);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(BOARD_MAX);

  logic       ent_ev;
  logic       sel_ev;
  logic       modo_cpu;
  logic [2:0] proximo;
  estado_t    estado;

  detector_borda u_borda_enter (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .botao  (enter),
    .evento (ent_ev)
  );

  detector_borda u_borda_select (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .botao  (select),
    .evento (sel_ev)
  );

  assign proximo = next_tipo(tipo, QT);

  // Every branch tests ent_ev before sel_ev, so a simultaneous select is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= ST_IDLE;
      modo_cpu   <= 1'b0;
      ready      <= 1'b0;
      valida     <= 1'b0;
      gravar     <= 1'b0;
      erro       <= 1'b0;
      tipo       <= TIPO_NENHUM;
      jogador    <= 1'b0;
      X1         <= '0;
      Y1         <= '0;
      direcao    <= 1'b0;
      orientacao <= 1'b0;
      restantes  <= '0;
    end else if (enable) begin
      valida <= 1'b0;
      gravar <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        ST_IDLE: begin
          if (ent_ev) begin
            // Opponent type is latched here only; later mode changes are ignored.
            modo_cpu  <= mode;
            tipo      <= PRIMEIRO;
            restantes <= contagem(PRIMEIRO, QT);
            if (PRIMEIRO == TIPO_NENHUM) begin
              ready  <= 1'b1;
              estado <= ST_PRONTO;
            end else begin
              estado <= ST_DIRECAO;
            end
          end
        end
        ST_DIRECAO: begin
          if (ent_ev)      estado  <= ST_ORIENTACAO;
          else if (sel_ev) direcao <= ~direcao;
        end
        ST_ORIENTACAO: begin
          if (ent_ev)      estado     <= ST_DEF_X;
          else if (sel_ev) orientacao <= ~orientacao;
        end
        ST_DEF_X: begin
          if (ent_ev)      estado <= ST_DEF_Y;
          else if (sel_ev) X1     <= (X1 == COORD_MAX) ? '0 : X1 + COORD_W'(1);
        end
        ST_DEF_Y: begin
          if (ent_ev) begin
            valida <= 1'b1;
            estado <= ST_VERIFICA;
          end else if (sel_ev) begin
            Y1 <= (Y1 == COORD_MAX) ? '0 : Y1 + COORD_W'(1);
          end
        end
        // check_done is deliberately not looked at while the request is out.
        ST_VERIFICA: estado <= ST_ESPERA;
        ST_ESPERA: begin
          if (check_done) begin
            if (conflito) begin
              erro   <= 1'b1;
              estado <= ST_DIRECAO;
            end else begin
              estado <= ST_ARMAZENA;
            end
          end
        end
        ST_ARMAZENA: begin
          if (ent_ev) begin
            gravar <= 1'b1;
            estado <= ST_DIRECAO;
            if (restantes > 4'd1) begin
              restantes <= restantes - 4'd1;
            end else if (proximo != TIPO_NENHUM) begin
              tipo      <= proximo;
              restantes <= contagem(proximo, QT);
            end else if (!jogador && !modo_cpu) begin
              jogador   <= 1'b1;
              tipo      <= PRIMEIRO;
              restantes <= contagem(PRIMEIRO, QT);
            end else begin
              ready     <= 1'b1;
              tipo      <= TIPO_NENHUM;
              restantes <= '0;
              estado    <= ST_PRONTO;
            end
          end
        end
        ST_PRONTO: estado <= ST_PRONTO;
        default:   estado <= ST_IDLE;
      endcase
    end
  end

endmodule
